// File: rtl/multi_pkg.sv
// Shared definitions for the multi_top serial datapath and its sequencer.
// Holds the sequencer state encoding and the default datapath geometry.
package multi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        RUN  = 2'd2,
        FIN  = 2'd3
    } state_t;

    localparam int W_DEF   = 8;
    localparam int RW_DEF  = 8;
    localparam int LAT_DEF = 1;

endpackage

// File: rtl/multi_if.sv
// Parallel-side start/done handshake of the multi_top sequencer.
// The requester is the master; the sequencer is the slave.
interface multi_if #(
    parameter int W  = 8,
    parameter int RW = 8
);

    logic          START;
    logic [W-1:0]  OPA;
    logic [W-1:0]  OPB;
    logic          BUSY;
    logic          DONE;
    logic [RW-1:0] RES;

    modport master (
        output START, OPA, OPB,
        input  BUSY, DONE, RES
    );

    modport slave (
        input  START, OPA, OPB,
        output BUSY, DONE, RES
    );

endinterface

// File: rtl/multi_piso.sv
// Parallel-load, right-shift register; LSB is the serial output.
// Zeros are shifted in from the top so exhausted operands read as 0.
module multi_piso #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] d,
    output logic         q
);

    logic [W-1:0] r;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r <= '0;
        end else if (load) begin
            r <= d;
        end else if (shift) begin
            r <= r >> 1;
        end
    end

    assign q = r[0];

endmodule

// File: rtl/multi_seq.sv
// Sequencer for the 1-bit serial datapath multi_top: serializes two
// operands LSB-first, collects RW result bits, returns a parallel word.
module multi_seq
    import multi_pkg::*;
#(
    parameter int W   = W_DEF,
    parameter int RW  = RW_DEF,
    parameter int LAT = LAT_DEF
) (
    input  logic  CLK,
    input  logic  RST,
    multi_if.slave bus,
    output logic  DP_RST,
    output logic  DP_A,
    output logic  DP_B,
    input  logic  DP_O
);

    localparam int NRUN = LAT + RW;
    localparam int CW   = $clog2(NRUN + 1);

    state_t        state;
    state_t        nxt;
    logic [CW-1:0] cnt;
    logic [RW-1:0] res;
    logic [RW:0]   cat;
    logic          sa;
    logic          sb;
    logic          load;
    logic          shift;
    logic          last;
    logic          drive;
    logic          cap;

    assign load  = (state == IDLE) && bus.START;
    assign shift = (state == CLR) || (state == RUN);
    assign last  = int'(cnt) == NRUN - 1;
    assign cap   = (state == RUN) && (int'(cnt) >= LAT);
    assign cat   = {DP_O, res};

    // DP_A/DP_B are registered, so they are loaded one cycle ahead:
    // the CLR edge presents bit 0, each RUN edge presents bit cnt+1.
    assign drive = (state == CLR) ||
                   ((state == RUN) && !last && (int'(cnt) + 1 < W));

    multi_piso #(.W(W)) u_pa (
        .CLK   (CLK),
        .RST   (RST),
        .load  (load),
        .shift (shift),
        .d     (bus.OPA),
        .q     (sa)
    );

    multi_piso #(.W(W)) u_pb (
        .CLK   (CLK),
        .RST   (RST),
        .load  (load),
        .shift (shift),
        .d     (bus.OPB),
        .q     (sb)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (bus.START) nxt = CLR;
            CLR:     nxt = RUN;
            RUN:     if (last) nxt = FIN;
            FIN:     nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt  <= '0;
            res  <= '0;
            DP_A <= 1'b0;
            DP_B <= 1'b0;
        end else begin
            if (load) begin
                cnt <= '0;
            end else if (state == RUN) begin
                cnt <= cnt + 1'b1;
            end
            // First captured O bit ends up in RES[0] after RW shifts.
            if (load) begin
                res <= '0;
            end else if (cap) begin
                res <= cat[RW:1];
            end
            DP_A <= drive ? sa : 1'b0;
            DP_B <= drive ? sb : 1'b0;
        end
    end

    assign bus.BUSY = state != IDLE;
    assign bus.DONE = state == FIN;
    assign bus.RES  = res;
    assign DP_RST   = RST || (state == CLR);

endmodule
